ge_p3_convert_seq: RTL and testbench
====================================

# ge_p3_convert_seq

Sequential, parametrised successor to the combinational P3→P2 copy stage in the Ed25519 group-element layer. It accepts an extended-coordinate point (X, Y, Z, T), each a signed field element of LIMBS limbs. It produces one of several derived point formats by limb-serial processing under a valid/ready handshake. It sits between the scalar-multiply sequencer and the point add/double units, so one shared block can replace the per-format converters.

## Interface
Parameters:
- LIMBS, 10, limbs per field element.
- LIMB_W, 32, bits per limb; field element width FW = LIMBS*LIMB_W (320 default).
- LPC, 1, limbs processed per cycle; must divide LIMBS. G = LIMBS/LPC groups.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input point and mode are valid.
- in_ready  out  1  block can accept a point; high only in IDLE.
- mode  in  2  0 = P3→P2, 1 = P3→partial cached, 2 = negate, 3 = reserved.
- p_X, p_Y, p_Z, p_T  in  FW, signed  input field elements; limb i occupies bits [i*LIMB_W +: LIMB_W].
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts result.
- r_X, r_Y, r_Z, r_T  out  FW, signed  result field elements, same limb layout.
- out_err  out  1  result was produced from reserved mode 3; qualified by out_valid.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid && in_ready, latch p_X..p_T and mode, clear the group counter, and go to RUN.
- RUN: each cycle, compute limbs [cnt*LPC, cnt*LPC+LPC-1] of all four outputs into the result registers, then increment cnt. After group G-1 is computed, go to DONE.
- DONE: out_valid=1. r_* and out_err are stable and must not change while out_valid is high. On out_valid && out_ready, go to IDLE.
- Per-limb arithmetic is independent two's-complement LIMB_W-bit arithmetic that wraps modulo 2^LIMB_W. There is no carry or borrow between limbs. This matches fe_add/fe_sub/fe_neg semantics; reduction is downstream.
- Mode 0 (P3→P2): r_X=X, r_Y=Y, r_Z=Z, r_T=0.
- Mode 1 (partial cached): r_X=Y+X, r_Y=Y−X, r_Z=Z, r_T=T. The T·2d multiply is done downstream.
- Mode 2 (negate): r_X=−X, r_Y=Y, r_Z=Z, r_T=−T.
- Mode 3: computed exactly as mode 0, with out_err=1. For modes 0–2, out_err=0.
- Inputs are sampled only at the accept edge. Changes to p_* or mode during RUN/DONE have no effect.
- Result registers are not cleared between operations. Only out_valid qualifies them.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, so in_ready=1.
  - cnt=0, out_valid=0, busy=0, out_err=0, all r_* = 0.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No result is emitted, and the first cycle after deassertion is IDLE.
- Latency: accept edge k → out_valid high in the cycle after edge k+G (G RUN cycles). Default G=10; with LPC=LIMBS, G=1.
- Throughput: the minimum interval between accepts is G+2 cycles, reached when out_ready is held high. There is no accept in the same cycle as the result handshake, because in_ready is low in DONE.
- Backpressure: DONE is held indefinitely while out_ready=0, and in_ready stays 0.
- in_ready and out_valid are pure decodes of registered state, with no combinational path from in_valid or out_ready.

## Test plan
- Mode 0, limb i of X/Y/Z/T = i+1, 100+i, 200+i, 300+i, out_ready=1:
  - out_valid is asserted exactly 11 cycles after the accept edge (LPC=1).
  - r_X/r_Y/r_Z match the inputs and r_T=0.
  - in_ready returns 1 one cycle after the handshake.
- Mode 1, X limb i = i+1, Y limb i = 100:
  - r_X limb i = 101+i and r_Y limb i = 99−i.
  - Wrap case, X limb0 = 0x7FFFFFFF, Y limb0 = 1: r_X limb0 = 0x80000000, and limb1 is unaffected (no carry).
- Mode 2, X limb0 = 5, X limb1 = 0x80000000, T limb0 = 0xFFFFFFFF:
  - r_X limb0 = 0xFFFFFFFB and r_X limb1 = 0x80000000.
  - r_T limb0 = 1; r_Y and r_Z are unchanged.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid, toggling p_* and in_valid throughout.
  - r_* stay stable and in_ready stays 0.
  - Exactly one result is delivered when out_ready rises.
- Reset mid-RUN: assert rst_n=0 at RUN group 4.
  - All outputs go to zero asynchronously and in_ready=1.
  - A new mode-0 operation after release completes normally in 11 cycles.
- Mode 3 plus parametrisation: mode 3 gives mode-0 data with out_err=1. Rerun the mode-1 scenario with LPC=5 (latency 3) and LPC=10 (latency 2); results are identical.

Source files
------------

// File: rtl/ge_p3_convert_seq.sv
// Limb-serial converter from extended (P3) points to P2, partial-cached or negated form.
// LPC per-limb lanes share one latched operand set and fill the result registers group by group.

module ge_p3_convert_limb #(
    parameter int W = 32
) (
    input  logic [1:0]   mode,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic [W-1:0] t,
    output logic [W-1:0] rx,
    output logic [W-1:0] ry,
    output logic [W-1:0] rz,
    output logic [W-1:0] rt
);
    // Plain modulo-2^W arithmetic: no carry crosses a limb boundary.
    always_comb begin
        rx = x;
        ry = y;
        rz = z;
        rt = '0;
        case (mode)
            2'd1: begin
                rx = y + x;
                ry = y - x;
                rt = t;
            end
            2'd2: begin
                rx = -x;
                rt = -t;
            end
            default: ;
        endcase
    end
endmodule

module ge_p3_convert_seq #(
    parameter int LIMBS  = 10,
    parameter int LIMB_W = 32,
    parameter int LPC    = 1,
    localparam int FW    = LIMBS * LIMB_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           mode,
    input  logic signed [FW-1:0] p_X,
    input  logic signed [FW-1:0] p_Y,
    input  logic signed [FW-1:0] p_Z,
    input  logic signed [FW-1:0] p_T,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [FW-1:0] r_X,
    output logic signed [FW-1:0] r_Y,
    output logic signed [FW-1:0] r_Z,
    output logic signed [FW-1:0] r_T,
    output logic                 out_err,
    output logic                 busy
);
    localparam int G  = LIMBS / LPC;
    localparam int CW = (G > 1) ? $clog2(G) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      mode_q;
    logic [FW-1:0]   x_q, y_q, z_q, t_q;

    logic [LPC-1:0][LIMB_W-1:0] lx, ly, lz, lt;
    logic [LPC-1:0][LIMB_W-1:0] ox, oy, oz, ot;

    for (genvar j = 0; j < LPC; j++) begin : g_lane
        assign lx[j] = x_q[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W];
        assign ly[j] = y_q[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W];
        assign lz[j] = z_q[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W];
        assign lt[j] = t_q[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W];

        ge_p3_convert_limb #(.W(LIMB_W)) u_limb (
            .mode (mode_q),
            .x    (lx[j]),
            .y    (ly[j]),
            .z    (lz[j]),
            .t    (lt[j]),
            .rx   (ox[j]),
            .ry   (oy[j]),
            .rz   (oz[j]),
            .rt   (ot[j])
        );
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            t_q     <= '0;
            r_X     <= '0;
            r_Y     <= '0;
            r_Z     <= '0;
            r_T     <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x_q    <= p_X;
                    y_q    <= p_Y;
                    z_q    <= p_Z;
                    t_q    <= p_T;
                    mode_q <= mode;
                    cnt    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    for (int j = 0; j < LPC; j++) begin
                        r_X[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W] <= ox[j];
                        r_Y[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W] <= oy[j];
                        r_Z[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W] <= oz[j];
                        r_T[(int'(cnt) * LPC + j) * LIMB_W +: LIMB_W] <= ot[j];
                    end
                    if (cnt == CW'(G - 1)) begin
                        out_err <= (mode_q == 2'd3);
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ge_p3_convert_seq.sv
// Directed bench for ge_p3_convert_seq; LPC=1, 5 and 10 instances share one stimulus.

module tb_ge_p3_convert_seq;
    localparam int FW = 320;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b1;
    logic [1:0]           mode = 2'd0;
    logic signed [FW-1:0] px = '0, py = '0, pz = '0, pt = '0;

    logic ir1, ov1, oe1, b1, ir5, ov5, oe5, b5, ir10, ov10, oe10, b10;
    logic signed [FW-1:0] rx1, ry1, rz1, rt1, rx5, ry5, rz5, rt5, rx10, ry10, rz10, rt10;

    ge_p3_convert_seq #(.LPC(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .mode(mode),
        .p_X(px), .p_Y(py), .p_Z(pz), .p_T(pt), .out_valid(ov1), .out_ready(out_ready),
        .r_X(rx1), .r_Y(ry1), .r_Z(rz1), .r_T(rt1), .out_err(oe1), .busy(b1));
    ge_p3_convert_seq #(.LPC(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir5), .mode(mode),
        .p_X(px), .p_Y(py), .p_Z(pz), .p_T(pt), .out_valid(ov5), .out_ready(out_ready),
        .r_X(rx5), .r_Y(ry5), .r_Z(rz5), .r_T(rt5), .out_err(oe5), .busy(b5));
    ge_p3_convert_seq #(.LPC(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir10), .mode(mode),
        .p_X(px), .p_Y(py), .p_Z(pz), .p_T(pt), .out_valid(ov10), .out_ready(out_ready),
        .r_X(rx10), .r_Y(ry10), .r_Z(rz10), .r_T(rt10), .out_err(oe10), .busy(b10));

    int passes = 0, fails = 0, total = 0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] ramp(input int base, input int step);
        logic [FW-1:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = 32'(base + step * i);
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Latency counts edges with the accept edge as 1; 0 means never seen.
    task automatic run_op(input logic [1:0] m, output int l1, output int l5, output int l10);
        int n;
        mode = m;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        l1 = 0; l5 = 0; l10 = 0; n = 1;
        while (l1 == 0 && n <= 40) begin
            if (ov5 && l5 == 0) l5 = n;
            if (ov10 && l10 == 0) l10 = n;
            if (ov1) l1 = n;
            else begin
                tick;
                n++;
            end
        end
    endtask

    logic [FW-1:0] ex, ey;
    int l1, l5, l10, deliv;

    initial begin
        #2;
        chk("rst_in_ready", ir1, 1);
        chk("rst_out_valid", ov1, 0);
        chk("rst_busy", b1, 0);
        chk("rst_out_err", oe1, 0);
        chk("rst_r_X", rx1, 0);
        chk("rst_r_T", rt1, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // mode 0
        px = ramp(1, 1); py = ramp(100, 1); pz = ramp(200, 1); pt = ramp(300, 1);
        run_op(2'd0, l1, l5, l10);
        chk("m0_latency", l1, 11);
        chk("m0_r_X", rx1, ramp(1, 1));
        chk("m0_r_Y", ry1, ramp(100, 1));
        chk("m0_r_Z", rz1, ramp(200, 1));
        chk("m0_r_T", rt1, 0);
        chk("m0_err", oe1, 0);
        tick;
        chk("m0_in_ready_back", ir1, 1);
        chk("m0_out_valid_drop", ov1, 0);

        // mode 1 on all three lane widths
        py = ramp(100, 0);
        run_op(2'd1, l1, l5, l10);
        ex = ramp(101, 1);
        ey = ramp(99, -1);
        chk("m1_latency1", l1, 11);
        chk("m1_latency5", l5, 3);
        chk("m1_latency10", l10, 2);
        chk("m1_r_X", rx1, ex);
        chk("m1_r_Y", ry1, ey);
        chk("m1_r_Z", rz1, ramp(200, 1));
        chk("m1_r_T", rt1, ramp(300, 1));
        chk("m1_lpc5_r_X", rx5, ex);
        chk("m1_lpc5_r_Y", ry5, ey);
        chk("m1_lpc10_r_X", rx10, ex);
        chk("m1_lpc10_r_Y", ry10, ey);
        tick;

        // mode 1 wrap: no carry into limb 1
        px[31:0] = 32'h7FFF_FFFF;
        py[31:0] = 32'h0000_0001;
        run_op(2'd1, l1, l5, l10);
        chk("m1w_X_limb0", rx1[31:0], 32'h8000_0000);
        chk("m1w_X_limb1", rx1[63:32], 32'd102);
        chk("m1w_Y_limb0", ry1[31:0], 32'h8000_0002);
        chk("m1w_lpc10_X_limb0", rx10[31:0], 32'h8000_0000);
        tick;

        // mode 2
        px = ramp(1, 1); py = ramp(100, 1); pt = ramp(300, 1);
        px[31:0] = 32'd5;
        px[63:32] = 32'h8000_0000;
        pt[31:0] = 32'hFFFF_FFFF;
        run_op(2'd2, l1, l5, l10);
        chk("m2_X_limb0", rx1[31:0], 32'hFFFF_FFFB);
        chk("m2_X_limb1", rx1[63:32], 32'h8000_0000);
        chk("m2_X_limb2", rx1[95:64], 32'hFFFF_FFFD);
        chk("m2_T_limb0", rt1[31:0], 32'd1);
        chk("m2_T_limb1", rt1[63:32], 32'hFFFF_FED3);
        chk("m2_r_Y", ry1, ramp(100, 1));
        chk("m2_r_Z", rz1, ramp(200, 1));
        tick;

        // mode 3
        px = ramp(1, 1);
        run_op(2'd3, l1, l5, l10);
        chk("m3_err", oe1, 1);
        chk("m3_err_lpc10", oe10, 1);
        chk("m3_r_X", rx1, ramp(1, 1));
        chk("m3_r_T", rt1, 0);
        tick;

        // backpressure
        out_ready = 1'b0;
        px = ramp(11, 2); py = ramp(50, 3); pz = ramp(900, 1); pt = ramp(7, 7);
        run_op(2'd0, l1, l5, l10);
        chk("bp_latency", l1, 11);
        for (int i = 0; i < 20; i++) begin
            px = ~px; py = py + 1; pz = ~pz; pt = pt ^ {FW{1'b1}};
            in_valid = i[0];
            mode = 2'(i);
            tick;
            chk("bp_in_ready", ir1, 0);
            chk("bp_out_valid", ov1, 1);
            chk("bp_r_X", rx1, ramp(11, 2));
            chk("bp_r_Y", ry1, ramp(50, 3));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        deliv = ov1 ? 1 : 0;
        tick;
        chk("bp_in_ready_back", ir1, 1);
        for (int i = 0; i < 5; i++) begin
            if (ov1 && out_ready) deliv++;
            tick;
        end
        chk("bp_deliveries", deliv, 1);

        // reset while RUN is on group 4
        px = ramp(1, 1); py = ramp(100, 1); pz = ramp(200, 1); pt = ramp(300, 1);
        mode = 2'd0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (4) tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", ir1, 1);
        chk("mr_out_valid", ov1, 0);
        chk("mr_busy", b1, 0);
        chk("mr_r_X", rx1, 0);
        chk("mr_r_Z", rz1, 0);
        tick;
        rst_n = 1'b1;
        tick;
        px = ramp(7, 1); pz = ramp(40, 2);
        run_op(2'd0, l1, l5, l10);
        chk("mr_after_latency", l1, 11);
        chk("mr_after_r_X", rx1, ramp(7, 1));
        chk("mr_after_r_Z", rz1, ramp(40, 2));
        tick;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
